serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor computing DIFF = A - B - BIN, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor_full_subtractor.sv | 41 ++++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t SHIFT = 2'b01;
    localparam state_t DONE  = 2'b10;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes of the serial subtractor, bundled as one interface.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cells: a half subtractor and a full subtractor built from two of them.

// d = x - y, bo set when y > x.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// d = x - y - bi; the two partial borrows can never both be set, so OR merges them.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x  (x),
        .y  (y),
        .d  (d1),
        .bo (b1)
    );

    half_subtractor u_hs1 (
        .x  (d1),
        .y  (bi),
        .d  (d),
        .bo (b2)
    );

    assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts parallel operands, subtracts one bit per clock LSB first
// through a single full-subtractor cell, then presents the parallel result until taken.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] d_sh_reg;
    logic             brw_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    logic             d_bit;
    logic             brw_next;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_reg == IDLE) && bus.in_valid;
    assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST_BIT);

    // The only arithmetic in the block: one cell working on the current LSBs.
    full_subtractor u_fs (
        .d  (d_bit),
        .bo (brw_next),
        .x  (a_sh_reg[0]),
        .y  (b_sh_reg[0]),
        .bi (brw_reg)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the spare encoding falls back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = accept ? SHIFT : IDLE;
            SHIFT:   state_next = last_bit ? DONE : SHIFT;
            DONE:    state_next = bus.out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags decoded from the state register only, so no input reaches an output.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand load, serial shifting and capture of the finished result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            d_sh_reg <= '0;
            brw_reg  <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg <= bus.a;
            b_sh_reg <= bus.b;
            brw_reg  <= bus.bin;
            cnt_reg  <= '0;
        end else if (state_reg == SHIFT) begin
            a_sh_reg <= a_sh_reg >> 1;
            b_sh_reg <= b_sh_reg >> 1;
            d_sh_reg <= {d_bit, d_sh_reg[WIDTH-1:1]};
            brw_reg  <= brw_next;
            if (last_bit) begin
                // Include the bit computed this cycle; the shift register is one step behind.
                diff_reg <= {d_bit, d_sh_reg[WIDTH-1:1]};
                bout_reg <= brw_next;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.diff = diff_reg;
    assign bus.bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    // Reference: plain integer subtraction, result taken modulo 2^w, borrow when negative.
    function automatic logic [31:0] ref_sub(input int w, input int a, input int b, input int bin);
        int r;
        int d;
        r = a - b - bin;
        d = (r + (1 << w)) & ((1 << w) - 1);
        return 32'(((r < 0) ? (1 << w) : 0) | d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands to the WIDTH=4 block, take the acceptance edge, wait (bounded) for out_valid.
    task automatic launch4(input int a, input int b, input int bin, output int lat);
        chk("in_ready_idle4", 32'(if4.in_ready), 32'd1);
        if4.a = 4'(a);
        if4.b = 4'(b);
        if4.bin = bin[0];
        if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Complete WIDTH=4 operation with latency, result and release checks.
    task automatic op4(input int a, input int b, input int bin);
        int lat;
        logic [31:0] exp;
        exp = ref_sub(4, a, b, bin);
        launch4(a, b, bin, lat);
        chk("latency4", 32'(lat), 32'd4);
        chk("result4", {27'd0, if4.bout, if4.diff}, exp);
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("release4", {30'd0, if4.out_valid, if4.in_ready}, 32'b01);
    endtask

    // Complete WIDTH=8 operation.
    task automatic op8(input int a, input int b, input int bin);
        int lat;
        chk("in_ready_idle8", 32'(if8.in_ready), 32'd1);
        if8.a = 8'(a);
        if8.b = 8'(b);
        if8.bin = bin[0];
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency8", 32'(lat), 32'd8);
        chk("result8", {23'd0, if8.bout, if8.diff}, ref_sub(8, a, b, bin));
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        chk("release8", {30'd0, if8.out_valid, if8.in_ready}, 32'b01);
        $display("op8 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d", a, b, bin, if8.diff, if8.bout);
    endtask

    initial begin
        int lat;
        int cyc;
        int acc[$];
        logic [4:0] res[$];
        logic [4:0] held;
        logic hs_in;
        logic hs_out;

        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;

        // Reset state.
        tick();
        chk("reset_flags", {30'd0, if4.out_valid, if4.in_ready}, 32'b01);
        chk("reset_result", {27'd0, if4.bout, if4.diff}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed examples.
        op4(5, 3, 0);
        $display("dir a=5 b=3 bin=0 -> diff=%b bout=%0d", if4.diff, if4.bout);
        op4(3, 5, 0);
        $display("dir a=3 b=5 bin=0 -> diff=%b bout=%0d", if4.diff, if4.bout);
        op4(0, 0, 1);
        $display("dir a=0 b=0 bin=1 -> diff=%b bout=%0d", if4.diff, if4.bout);
        chk("retained_after_idle", {27'd0, if4.bout, if4.diff}, 32'h1f);

        // Backpressure in DONE, with in_valid offered and not taken even on the release cycle.
        launch4(3, 5, 0, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        held = {if4.bout, if4.diff};
        chk("bp_result", {27'd0, held}, ref_sub(4, 3, 5, 0));
        if4.a = 4'd7; if4.b = 4'd1; if4.bin = 1'b0; if4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_flags", {30'd0, if4.out_valid, if4.in_ready}, 32'b10);
            chk("bp_hold_result", {27'd0, if4.bout, if4.diff}, {27'd0, held});
        end
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("bp_release_not_accepted", {30'd0, if4.out_valid, if4.in_ready}, 32'b01);
        if4.in_valid = 1'b0;
        $display("backpressure held diff=%b bout=%0d for 10 clk", held[3:0], held[4]);
        tick();

        // Asynchronous reset during the second SHIFT clock.
        if4.a = 4'd5; if4.b = 4'd3; if4.bin = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_flags", {30'd0, if4.out_valid, if4.in_ready}, 32'b01);
        chk("midreset_result", {27'd0, if4.bout, if4.diff}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_partial_result", 32'(if4.out_valid), 32'd0);
        end
        op4(9, 9, 0);
        $display("after reset a=9 b=9 -> diff=%0d bout=%0d", if4.diff, if4.bout);

        // Back-to-back with out_ready tied high and in_valid held.
        if4.out_ready = 1'b1;
        if4.a = 4'd15; if4.b = 4'd1; if4.bin = 1'b0; if4.in_valid = 1'b1;
        cyc = 0;
        while (res.size() < 2 && cyc < 60) begin
            hs_in  = if4.in_valid & if4.in_ready;
            hs_out = if4.out_valid & if4.out_ready;
            if (hs_out) res.push_back({if4.bout, if4.diff});
            tick();
            if (hs_in) begin
                acc.push_back(cyc);
                if (acc.size() == 1) begin
                    if4.a = 4'd1; if4.b = 4'd15;
                end else begin
                    if4.in_valid = 1'b0;
                end
            end
            cyc++;
        end
        chk("b2b_accepts", 32'(acc.size()), 32'd2);
        chk("b2b_results", 32'(res.size()), 32'd2);
        if (acc.size() == 2) chk("b2b_period", 32'(acc[1] - acc[0]), 32'd6);
        if (res.size() == 2) begin
            chk("b2b_first", {27'd0, res[0]}, ref_sub(4, 15, 1, 0));
            chk("b2b_second", {27'd0, res[1]}, ref_sub(4, 1, 15, 0));
            $display("b2b results %0h %0h period %0d", res[0], res[1], (acc.size() == 2) ? acc[1] - acc[0] : -1);
        end
        if4.in_valid = 1'b0;
        tick();
        if4.out_ready = 1'b0;
        tick();

        // Exhaustive WIDTH=4.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    op4(a, b, bin);
        $display("exhaustive WIDTH=4 done, checks so far=%0d", checks);

        // Random WIDTH=8, with the extremes first.
        op8(0, 255, 1);
        op8(255, 0, 0);
        for (int i = 0; i < 150; i++)
            op8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
